// File: rtl/master_axi_sequencer_read_multi.sv
// Read sequencer for an AXI master: lets up to MAX_OUTSTANDING read-address
// transactions be in flight ahead of their read-data completions. It enables
// the AR and R controllers through enable/done handshakes and reports
// occupancy and idle status to the system side.
module master_axi_sequencer_read_multi #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                     clock,
    input  logic                                     clear,
    output logic                                     ar_control_enable,
    input  logic                                     ar_control_done,
    output logic                                     r_control_enable,
    input  logic                                     r_control_done,
    input  logic                                     drain,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
    output logic                                     idle
);

    localparam int COUNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [COUNT_WIDTH-1:0] ONE       = COUNT_WIDTH'(1);

    // Count of reads whose address was accepted but whose data has not finished.
    logic [COUNT_WIDTH-1:0] count_reg;
    logic [COUNT_WIDTH-1:0] count_next;

    // Done pulses only count when the matching enable is high. Because the
    // enables come from the registered count, this also rules out overflow
    // and underflow without any separate saturation logic.
    logic ar_done;
    logic r_done;

    // Enables and status depend only on the registered count and drain, so no
    // done input ever reaches an output combinationally.
    always_comb begin
        ar_control_enable = (count_reg < MAX_COUNT) && !drain;
        r_control_enable  = (count_reg != '0);
        idle              = (count_reg == '0);
        outstanding       = count_reg;
        ar_done           = ar_control_enable && ar_control_done;
        r_done            = r_control_enable && r_control_done;
    end

    // Next count: an address acceptance and a data completion in the same
    // cycle cancel out; either alone moves the count by one.
    always_comb begin
        count_next = count_reg;
        unique case ({ar_done, r_done})
            2'b10:   count_next = count_reg + ONE;
            2'b01:   count_next = count_reg - ONE;
            default: count_next = count_reg;
        endcase
    end

    // Count register; clear wins over any coincident done pulses.
    always_ff @(posedge clock) begin
        if (clear) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: tb/tb_master_axi_sequencer_read_multi.sv
// Directed bench: one instance with MAX_OUTSTANDING = 4 and one with 1,
// sharing a clock. Outputs are sampled 1 time unit after each rising edge.
module tb_master_axi_sequencer_read_multi;

    localparam int MAX_A = 4;
    localparam int MAX_B = 1;
    localparam int WA = $clog2(MAX_A + 1);
    localparam int WB = $clog2(MAX_B + 1);

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          a_clear, a_ar_done, a_r_done, a_drain;
    logic          a_ar_en, a_r_en, a_idle;
    logic [WA-1:0] a_out;

    logic          b_clear, b_ar_done, b_r_done, b_drain;
    logic          b_ar_en, b_r_en, b_idle;
    logic [WB-1:0] b_out;

    master_axi_sequencer_read_multi #(.MAX_OUTSTANDING(MAX_A)) dut_a (
        .clock             (clock),
        .clear             (a_clear),
        .ar_control_enable (a_ar_en),
        .ar_control_done   (a_ar_done),
        .r_control_enable  (a_r_en),
        .r_control_done    (a_r_done),
        .drain             (a_drain),
        .outstanding       (a_out),
        .idle              (a_idle)
    );

    master_axi_sequencer_read_multi #(.MAX_OUTSTANDING(MAX_B)) dut_b (
        .clock             (clock),
        .clear             (b_clear),
        .ar_control_enable (b_ar_en),
        .ar_control_done   (b_ar_done),
        .r_control_enable  (b_r_en),
        .r_control_done    (b_r_done),
        .drain             (b_drain),
        .outstanding       (b_out),
        .idle              (b_idle)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Check the full status of instance A.
    task automatic check_a(input string tag, input int cnt, input logic ar_en, input logic r_en, input logic idl);
        check({tag, ".out"},   32'(a_out),   32'(cnt));
        check({tag, ".ar_en"}, 32'(a_ar_en), 32'(ar_en));
        check({tag, ".r_en"},  32'(a_r_en),  32'(r_en));
        check({tag, ".idle"},  32'(a_idle),  32'(idl));
        $display("A %-12s out=%0d ar_en=%0b r_en=%0b idle=%0b", tag, a_out, a_ar_en, a_r_en, a_idle);
    endtask

    task automatic check_b(input string tag, input int cnt, input logic ar_en, input logic r_en, input logic idl);
        check({tag, ".out"},   32'(b_out),   32'(cnt));
        check({tag, ".ar_en"}, 32'(b_ar_en), 32'(ar_en));
        check({tag, ".r_en"},  32'(b_r_en),  32'(r_en));
        check({tag, ".idle"},  32'(b_idle),  32'(idl));
        $display("B %-12s out=%0d ar_en=%0b r_en=%0b idle=%0b", tag, b_out, b_ar_en, b_r_en, b_idle);
    endtask

    initial begin
        // Reset with ar_control_done held high on both instances.
        a_clear = 1; a_ar_done = 1; a_r_done = 0; a_drain = 0;
        b_clear = 1; b_ar_done = 1; b_r_done = 0; b_drain = 0;
        step();
        step();
        a_clear = 0; a_ar_done = 0;
        b_clear = 0; b_ar_done = 0;
        check_a("reset", 0, 1, 0, 1);
        check_b("reset", 0, 1, 0, 1);
        step();
        check_a("reset_hold", 0, 1, 0, 1);

        // Fill to the limit: five consecutive pulses, the fifth ignored.
        a_ar_done = 1;
        step(); check_a("fill1", 1, 1, 1, 0);
        step(); check_a("fill2", 2, 1, 1, 0);
        step(); check_a("fill3", 3, 1, 1, 0);
        step(); check_a("fill4", 4, 0, 1, 0);
        step(); check_a("fill5", 4, 0, 1, 0);
        a_ar_done = 0;

        // Back down to 2, then simultaneous events for three cycles.
        a_r_done = 1;
        step(); check_a("down3", 3, 1, 1, 0);
        step(); check_a("down2", 2, 1, 1, 0);
        a_ar_done = 1;
        step(); check_a("simul1", 2, 1, 1, 0);
        step(); check_a("simul2", 2, 1, 1, 0);
        step(); check_a("simul3", 2, 1, 1, 0);
        a_r_done = 0;
        step(); check_a("up3", 3, 1, 1, 0);
        a_ar_done = 0;

        // Drain: enable drops immediately; spurious AR done ignored.
        a_drain = 1;
        #1;
        check_a("drain_on", 3, 0, 1, 0);
        a_r_done = 1; a_ar_done = 1;
        step(); check_a("drain2", 2, 0, 1, 0);
        step(); check_a("drain1", 1, 0, 1, 0);
        step(); check_a("drain0", 0, 0, 0, 1);
        // Spurious R done at zero is ignored.
        step(); check_a("spur_r0", 0, 0, 0, 1);
        a_r_done = 0; a_ar_done = 0;
        a_drain = 0;
        #1;
        check_a("undrain", 0, 1, 0, 1);

        // Reset mid-operation together with an R done.
        a_ar_done = 1;
        step(); step(); step();
        a_ar_done = 0;
        check_a("pre_clr", 3, 1, 1, 0);
        a_clear = 1; a_r_done = 1;
        step();
        a_clear = 0; a_r_done = 0;
        check_a("mid_clr", 0, 1, 0, 1);

        // Degenerate MAX = 1: strict alternation.
        b_ar_done = 1;
        step(); check_b("b_ar", 1, 0, 1, 0);
        step(); check_b("b_ar_ign", 1, 0, 1, 0);
        b_ar_done = 0; b_r_done = 1;
        step(); check_b("b_r", 0, 1, 0, 1);
        step(); check_b("b_spur_r", 0, 1, 0, 1);
        b_ar_done = 1;
        step(); check_b("b_both0", 1, 0, 1, 0);
        step(); check_b("b_both1", 0, 1, 0, 1);
        b_ar_done = 0; b_r_done = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
